// File: rtl/i2c_tx_fifo_if.sv
// Bundle between the register interface / I2C engines and the TX command FIFO.
// The master side pushes, pops and programs the threshold; the FIFO is the slave.
interface i2c_tx_fifo_if #(
    parameter int DW    = 10,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
);
    logic          flush;
    logic          wr;
    logic [DW-1:0] din;
    logic          rd;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic [AW:0]   occ;
    logic [AW-1:0] thr;
    logic          thr_hit;
    logic          ovf;
    logic          udf;

    modport master (
        output flush, wr, din, rd, thr,
        input  dout, empty, full, occ, thr_hit, ovf, udf
    );

    modport slave (
        input  flush, wr, din, rd, thr,
        output dout, empty, full, occ, thr_hit, ovf, udf
    );
endinterface

// File: rtl/i2c_tx_fifo.sv
// First-word-fall-through command FIFO for the I2C transmit path.
// Words are {STOP, START, byte}; the head is visible on dout whenever non-empty.
module i2c_tx_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rstn,
    i2c_tx_fifo_if.slave    bus
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          empty;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == FULL_LVL);

    // A full FIFO still takes a push when a pop frees a slot the same cycle.
    assign wr_ok = bus.wr & (~full | bus.rd);
    assign rd_ok = bus.rd & ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        if (bus.flush) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + AW'(1);
            if (rd_ok) rptr_d = rptr_q + AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   occ_d = occ_q + (AW+1)'(1);
                2'b01:   occ_d = occ_q - (AW+1)'(1);
                default: occ_d = occ_q;
            endcase
            ovf_d = bus.wr & full & ~bus.rd;
            udf_d = bus.rd & empty;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Storage is deliberately left out of reset and untouched by flush.
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.flush) begin
            mem_q[wptr_q] <= bus.din;
        end
    end

    assign bus.dout    = empty ? '0 : mem_q[rptr_q];
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.occ     = occ_q;
    assign bus.thr_hit = (occ_q <= {1'b0, bus.thr});
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;
endmodule

// File: doc/i2c_tx_fifo.md
# i2c_tx_fifo

Transmit command FIFO feeding the I2C dynamic-mode controller and the byte-level master engine. It stores 10-bit command words written by the register interface: bit 9 = STOP after this byte, bit 8 = START (address byte), bits 7:0 = address/data, or the read byte count after a read address. The FIFO is first-word-fall-through (FWFT): the head word is presented on `dout` whenever the FIFO is not empty. Consumers sample the head combinationally with `empty` and in the same cycle as `rd`.

## Interface
Parameters:
- `DW`, 10, word width.
- `DEPTH`, 16, number of entries; must be a power of two, 2..256.
- `AW`, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; one clock, asynchronous, active-low.
- `flush`  in  1  synchronous FIFO reset from the control register (TX_FIFO_RST).
- `wr`  in  1  push strobe.
- `din`  in  DW  push data.
- `rd`  in  1  pop strobe.
- `dout`  out  DW  head word; all-zero while `empty`.
- `empty`  out  1  no entries.
- `full`  out  1  DEPTH entries.
- `occ`  out  AW+1  current entry count, 0..DEPTH.
- `thr`  in  AW  programmable threshold (TX_FIFO_PIRQ).
- `thr_hit`  out  1  level: `occ <= thr`.
- `ovf`  out  1  one-cycle pulse: push attempted while full (word dropped).
- `udf`  out  1  one-cycle pulse: pop attempted while empty (ignored).

## Operation
- Storage is a DEPTH×DW register array with write pointer `wptr` and read pointer `rptr`, each AW bits and wrapping modulo DEPTH. A registered count `occ` is kept alongside.
- `empty` = (occ==0); `full` = (occ==DEPTH). Both are decoded from the registered `occ`.
- `dout` = `empty` ? 0 : mem[rptr]. It is combinational from registered state, with no path from `rd`, `wr` or `din`.
- Accepted push (`wr_ok`) = `wr & (!full | rd)`. A push into a full FIFO with a simultaneous pop is accepted, because a slot frees that cycle.
- Accepted pop (`rd_ok`) = `rd & !empty`. There is no bypass: a push and pop together while empty accepts the push, ignores the pop, and raises `udf`.
- On `wr_ok`: mem[wptr] ← din, and wptr increments.
- On `rd_ok`: rptr increments.
- `occ` next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- `ovf` = `wr & full & !rd`, registered, so it is a one-cycle pulse in the cycle after the attempt.
- `udf` = `rd & empty`, registered in the same way.
- `flush` has top priority. Next cycle: pointers = 0, occ = 0, and `ovf`/`udf` = 0. Any `wr`/`rd` in the flush cycle is discarded with no error pulse. Memory contents are not cleared.
- `thr_hit` is combinational from `occ` and `thr`. With `thr` = 0 it asserts exactly when empty.

## Timing
- Reset values: wptr = rptr = 0, occ = 0, empty = 1, full = 0, dout = 0, ovf = udf = 0, thr_hit = 1. Memory is not reset.
- Push in cycle N into an empty FIFO: `empty` = 0 and `dout` = that word from N+1. In cycle N itself, `empty` = 1 and `dout` = 0.
- Pop in cycle N: `dout` shows the next entry from N+1, or 0 with `empty` = 1 if the FIFO is now empty.
  - This lets a consumer that pops a read-address word in N sample the count byte on `dout` at N+1.
- `occ`, `full` and `thr_hit` reflect the N-cycle operation from N+1.
- Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers return to 0 with no data corruption.
- Asynchronous reset mid-burst returns every output to its reset value immediately. Operation resumes on the first clock edge after `rstn` rises.

## Test plan
- Reset, then push 0x1A4 (START, addr 0x52 write), 0x033, 0x255 (STOP|0x55); pop three times.
  - Required: `dout` sequence 0x1A4, 0x033, 0x255; `occ` steps 3, 2, 1, 0; `empty` rises the cycle after the third pop, and `dout` = 0.
- FWFT latency: push 0x1A5 in cycle N.
  - Required: `empty` = 1 and `dout` = 0 at N; `empty` = 0 and `dout` = 0x1A5 at N+1.
  - Then pop at N+1 with 0x004 queued behind it: `dout` = 0x004 at N+2.
- DEPTH=16: fill with 0..15, then push 0x3FF.
  - Required: `full` = 1, `ovf` pulses once, and 0x3FF is never read.
  - Then push 0x111 together with a pop: `full` stays 1, `occ` stays 16, and the last word read is 0x111.
- Pop while empty, and a push+pop same cycle while empty.
  - Required: `udf` pulses once per attempt and `occ` ends at 1.
  - The pushed word appears on `dout` the next cycle.
- Wrap and flush: run 40 push/pop pairs with random data and check order.
  - Then with occ = 5, assert `flush` with `wr` = 1: next cycle occ = 0, empty = 1, no `ovf`.
- Threshold and reset: set `thr` = 3 and push 5 words; `thr_hit` must be 0 at occ 4 and 5, and 1 at occ ≤ 3.
  - Assert `rstn` low mid-pop: all outputs go to reset values asynchronously.
